gpio_input_debouncer: RTL and testbench
=======================================

// Module: gpio_input_debouncer
// PURPOSE
//   Conditions the board slide switches/buttons before they reach the SoC GPIO
//   inputs (i_gpio[31:16]). The block:
//   - synchronises each raw pad into clk_i;
//   - rejects bounce with a per-channel stability counter;
//   - emits one-cycle rise/fall pulses;
//   - keeps a sticky, maskable change-status vector with a level interrupt
//     for the core.
//   It sits between the FPGA top-level pads and the rv32i_soc GPIO input bus.
// PARAMETERS
//   NUM_INPUTS       16     number of independent input channels
//   SYNC_STAGES      2      flip-flops in each input synchroniser (>=2)
//   CNT_WIDTH        16     width of each stability counter
//   DEBOUNCE_CYCLES  50000  stable cycles before an input is accepted
//                           (1 ms at the 50 MHz core clock);
//                           2 <= DEBOUNCE_CYCLES <= 2**CNT_WIDTH-1
// PORTS
//   clk_i         in   1           core clock (CLK100MHZ/2)
//   reset_n       in   1           asynchronous, active-low reset
//   raw_i         in   NUM_INPUTS  raw asynchronous pad inputs
//   db_o          out  NUM_INPUTS  debounced level, registered
//   rise_o        out  NUM_INPUTS  1-cycle pulse when db_o goes 0->1
//   fall_o        out  NUM_INPUTS  1-cycle pulse when db_o goes 1->0
//   irq_mask_i    in   NUM_INPUTS  1 = edges on this channel set irq_status_o
//   irq_clr_i     in   NUM_INPUTS  write-1-to-clear pulse per status bit
//   irq_status_o  out  NUM_INPUTS  sticky edge-status bits
//   irq_o         out  1           OR of irq_status_o
// BEHAVIOUR
//   Reset values
//   - All synchroniser flops, counters, db_o, rise_o, fall_o and irq_status_o
//     are 0, so irq_o is 0.
//   - Reset is asynchronous.
//   - Reset asserted mid-count discards the count, and no edge pulse is
//     produced on release.
//   Per-channel operation (each channel is independent)
//   - s = output of the last synchroniser stage.
//   - s == db_o: the counter clears to 0. A glitch shorter than the window is
//     dropped and the count restarts.
//   - s != db_o and counter <  DEBOUNCE_CYCLES-1: the counter increments.
//   - s != db_o and counter == DEBOUNCE_CYCLES-1: db_o <= s and the counter
//     clears. On that same edge, rise_o or fall_o is set high for exactly one
//     cycle, coincident with the first cycle of the new db_o value.
//   - The counter never wraps; the terminal compare uses exact equality.
//   Latency
//   - A clean raw_i step, held steady, changes db_o after
//     SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
//   - This latency is identical for rising and falling steps.
//   Status and interrupt
//   - irq_status_o[i] is set on the edge after (rise_o[i] | fall_o[i]) &
//     irq_mask_i[i] is true.
//   - irq_status_o[i] is cleared on the edge after irq_clr_i[i] is high.
//   - Set and clear in the same cycle: set wins, so no event is lost.
//   - Masked channels still drive db_o, rise_o and fall_o. The mask only gates
//     status setting; it never clears existing status.
//   - irq_o = |irq_status_o, combinational from registers (glitch-free).
//   Simultaneous events
//   - Several channels may qualify in the same cycle; each gets its own pulse
//     and status bit.
// STRUCTURE
//   - Package gpio_db_pkg holds the default constants
//     (GPIO_DB_DEFAULT_CYCLES = 50000, GPIO_DB_CNT_W = 16) and an elaboration
//     function that checks the DEBOUNCE_CYCLES range.
//   - Sub-module debounce_channel implements one bit: synchroniser, counter,
//     db/rise/fall registers. It is instantiated NUM_INPUTS times in a
//     generate loop.
//   - The top level owns only the status/interrupt logic.
//   - Elaboration fails ($error) if a parameter is out of range.
// TESTING (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2, NUM_INPUTS=16)
//   1. raw_i[0] 0->1 held -> db_o[0]=1 exactly 10 edges later.
//      rise_o[0] is high for 1 cycle; no other channel moves.
//   2. raw_i[3] bounces 1,0,1,0 with 3-cycle pulses, then holds 1
//      -> db_o[3] changes once, 10 edges after the final transition;
//      exactly one rise_o[3] pulse.
//   3. raw_i[5] high for 7 stable cycles, then back low
//      -> db_o[5] stays 0 and no pulse is produced.
//   4. irq_mask_i=16'h0001, edges on ch0 and ch1
//      -> irq_status_o=16'h0001, irq_o=1. Then irq_clr_i=16'h0001 for 1 cycle
//      -> status 0, irq_o 0.
//   5. irq_clr_i[0] pulse in the same cycle as a new rise_o[0] with mask set
//      -> irq_status_o[0] stays 1.
//   6. reset_n low for 1 cycle at counter=5 on ch2, raw held high
//      -> all outputs 0. After release, db_o[2] rises 10 edges later with a
//      single rise pulse.

Source files
------------

// File: rtl/gpio_db_pkg.sv
// Shared constants and parameter range check for the GPIO input debouncer.
// Imported by the interface, the channel and the top level.
package gpio_db_pkg;

   localparam int GPIO_DB_NUM_INPUTS     = 16;
   localparam int GPIO_DB_SYNC_STAGES    = 2;
   localparam int GPIO_DB_CNT_W          = 16;
   localparam int GPIO_DB_DEFAULT_CYCLES = 50000;

   // DEBOUNCE_CYCLES must fit in the counter; the counter is capped at 31 bits so the range stays in int.
   function automatic bit gpio_db_params_ok(input int num_inputs, input int sync_stages,
                                            input int cnt_width, input int cycles);
      longint maxCount;
      maxCount = (64'sd1 <<< cnt_width) - 64'sd1;
      return (num_inputs >= 1) && (sync_stages >= 2) && (cnt_width >= 2) &&
             (cnt_width <= 31) && (cycles >= 2) && (longint'(cycles) <= maxCount);
   endfunction

endpackage

// File: rtl/gpio_input_debouncer_if.sv
// Bus between the board pads / GPIO block and the debouncer.
// The master drives pads, mask and clear; the slave (the debouncer) drives levels, pulses and status.
interface gpio_input_debouncer_if
   import gpio_db_pkg::*;
#(
   parameter int NUM_INPUTS = GPIO_DB_NUM_INPUTS
);
   logic [NUM_INPUTS-1:0] raw_i;
   logic [NUM_INPUTS-1:0] db_o;
   logic [NUM_INPUTS-1:0] rise_o;
   logic [NUM_INPUTS-1:0] fall_o;
   logic [NUM_INPUTS-1:0] irq_mask_i;
   logic [NUM_INPUTS-1:0] irq_clr_i;
   logic [NUM_INPUTS-1:0] irq_status_o;
   logic                  irq_o;

   modport master (
      output raw_i, irq_mask_i, irq_clr_i,
      input  db_o, rise_o, fall_o, irq_status_o, irq_o
   );

   modport slave (
      input  raw_i, irq_mask_i, irq_clr_i,
      output db_o, rise_o, fall_o, irq_status_o, irq_o
   );
endinterface

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter and registered level / edge pulses.
// The level only moves after the synchronised input has disagreed with it for DEBOUNCE_CYCLES edges.
module debounce_channel
   import gpio_db_pkg::*;
#(
   parameter int SYNC_STAGES     = GPIO_DB_SYNC_STAGES,
   parameter int CNT_WIDTH       = GPIO_DB_CNT_W,
   parameter int DEBOUNCE_CYCLES = GPIO_DB_DEFAULT_CYCLES
) (
   input  logic clk_i,
   input  logic reset_n,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_db;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
      end
   end

   // Any agreement restarts the window, so a glitch shorter than the window never reaches db_o.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_db   <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_sync == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == TERMINAL) begin
            r_cnt  <= '0;
            r_db   <= w_sync;
            r_rise <= w_sync;
            r_fall <= ~w_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign db_o   = r_db;
   assign rise_o = r_rise;
   assign fall_o = r_fall;

endmodule

// File: rtl/gpio_input_debouncer.sv
// Debounces the board switches/buttons feeding the SoC GPIO inputs and raises a
// sticky, maskable edge interrupt. Per-channel conditioning lives in debounce_channel.
module gpio_input_debouncer
   import gpio_db_pkg::*;
#(
   parameter int NUM_INPUTS      = GPIO_DB_NUM_INPUTS,
   parameter int SYNC_STAGES     = GPIO_DB_SYNC_STAGES,
   parameter int CNT_WIDTH       = GPIO_DB_CNT_W,
   parameter int DEBOUNCE_CYCLES = GPIO_DB_DEFAULT_CYCLES
) (
   input  logic                   clk_i,
   input  logic                   reset_n,
   gpio_input_debouncer_if.slave  bus
);

   if (!gpio_db_params_ok(NUM_INPUTS, SYNC_STAGES, CNT_WIDTH, DEBOUNCE_CYCLES)) begin : g_param_err
      $error("gpio_input_debouncer: parameter out of range (NUM_INPUTS=%0d SYNC_STAGES=%0d CNT_WIDTH=%0d DEBOUNCE_CYCLES=%0d)",
             NUM_INPUTS, SYNC_STAGES, CNT_WIDTH, DEBOUNCE_CYCLES);
   end

   logic [NUM_INPUTS-1:0] w_db;
   logic [NUM_INPUTS-1:0] w_rise;
   logic [NUM_INPUTS-1:0] w_fall;
   logic [NUM_INPUTS-1:0] r_status;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .CNT_WIDTH       (CNT_WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk_i   (clk_i),
         .reset_n (reset_n),
         .raw_i   (bus.raw_i[i]),
         .db_o    (w_db[i]),
         .rise_o  (w_rise[i]),
         .fall_o  (w_fall[i])
      );
   end

   // Set is OR-ed in after the clear so an edge arriving with a clear is never lost.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_status <= '0;
      end else begin
         r_status <= (r_status & ~bus.irq_clr_i) | ((w_rise | w_fall) & bus.irq_mask_i);
      end
   end

   assign bus.db_o         = w_db;
   assign bus.rise_o       = w_rise;
   assign bus.fall_o       = w_fall;
   assign bus.irq_status_o = r_status;
   assign bus.irq_o        = |r_status;

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Scoreboard bench for gpio_input_debouncer with an 8-cycle debounce window.
// Stimulus pushes expected edge events; a negedge monitor pops and compares them.
module tb_gpio_input_debouncer;

   localparam int NI = 16;

   typedef struct {
      int              cyc;
      logic [NI-1:0]   rise;
      logic [NI-1:0]   fall;
      logic [NI-1:0]   db;
   } ev_t;

   logic clk_i;
   logic reset_n;
   int   cyc;
   int   checks;
   int   failures;
   ev_t  expQ[$];

   gpio_input_debouncer_if #(.NUM_INPUTS(NI)) bus();

   gpio_input_debouncer #(
      .NUM_INPUTS      (NI),
      .SYNC_STAGES     (2),
      .CNT_WIDTH       (16),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // Free-running clock and posedge counter used to timestamp events.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [NI-1:0] actual, input logic [NI-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [NI-1:0] raw);
      bus.raw_i = raw;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic pushEvent(input int delay, input logic [NI-1:0] rise,
                            input logic [NI-1:0] fall, input logic [NI-1:0] db);
      ev_t e;
      e.cyc  = cyc + delay;
      e.rise = rise;
      e.fall = fall;
      e.db   = db;
      expQ.push_back(e);
   endtask

   // Any cycle with a rise/fall pulse must match the next queued event exactly.
   always @(negedge clk_i) begin
      if ((bus.rise_o | bus.fall_o) != '0) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_edge: rise=%h fall=%h db=%h at cycle %0d, none expected",
                     bus.rise_o, bus.fall_o, bus.db_o, cyc);
         end else begin
            ev_t e;
            e = expQ.pop_front();
            checks++;
            if (cyc != e.cyc) begin
               failures++;
               $display("[TB] FAIL edge_cycle: got %0d expected %0d", cyc, e.cyc);
            end
            checkOutput("edge_rise", bus.rise_o, e.rise);
            checkOutput("edge_fall", bus.fall_o, e.fall);
            checkOutput("edge_db", bus.db_o, e.db);
         end
      end
   end

   initial begin
      checks         = 0;
      failures       = 0;
      reset_n        = 1'b0;
      bus.raw_i      = '0;
      bus.irq_mask_i = '0;
      bus.irq_clr_i  = '0;
      waitCycles(3);
      checkOutput("reset_db", bus.db_o, '0);
      checkOutput("reset_rise", bus.rise_o, '0);
      checkOutput("reset_fall", bus.fall_o, '0);
      checkOutput("reset_status", bus.irq_status_o, '0);
      checkOutput("reset_irq", {15'd0, bus.irq_o}, '0);
      reset_n = 1'b1;
      waitCycles(3);

      $display("[TB] clean rising step on ch0");
      applyStimulus(16'h0001);
      pushEvent(10, 16'h0001, 16'h0000, 16'h0001);
      waitCycles(9);
      checkOutput("t1_db_early", bus.db_o, 16'h0000);
      waitCycles(6);

      $display("[TB] bouncing input on ch3");
      applyStimulus(16'h0009); waitCycles(3);
      applyStimulus(16'h0001); waitCycles(3);
      applyStimulus(16'h0009); waitCycles(3);
      applyStimulus(16'h0001); waitCycles(3);
      applyStimulus(16'h0009);
      pushEvent(10, 16'h0008, 16'h0000, 16'h0009);
      waitCycles(15);

      $display("[TB] pulse one cycle short of the window on ch5");
      applyStimulus(16'h0029);
      waitCycles(7);
      applyStimulus(16'h0009);
      waitCycles(15);
      checkOutput("t3_db", bus.db_o, 16'h0009);

      $display("[TB] masked status with simultaneous edges on ch0/ch1");
      bus.irq_mask_i = 16'h0001;
      applyStimulus(16'h000A);
      pushEvent(10, 16'h0002, 16'h0001, 16'h000A);
      waitCycles(10);
      checkOutput("t4_status_pre", bus.irq_status_o, 16'h0000);
      waitCycles(1);
      checkOutput("t4_status", bus.irq_status_o, 16'h0001);
      checkOutput("t4_irq", {15'd0, bus.irq_o}, 16'h0001);
      waitCycles(2);
      bus.irq_clr_i = 16'h0001;
      waitCycles(1);
      bus.irq_clr_i = 16'h0000;
      checkOutput("t4_status_clr", bus.irq_status_o, 16'h0000);
      checkOutput("t4_irq_clr", {15'd0, bus.irq_o}, 16'h0000);

      $display("[TB] clear coincident with new rise on ch0");
      applyStimulus(16'h000B);
      pushEvent(10, 16'h0001, 16'h0000, 16'h000B);
      waitCycles(10);
      bus.irq_clr_i = 16'h0001;
      waitCycles(1);
      bus.irq_clr_i = 16'h0000;
      checkOutput("t5_set_wins", bus.irq_status_o, 16'h0001);
      bus.irq_clr_i = 16'h0001;
      waitCycles(1);
      bus.irq_clr_i = 16'h0000;
      checkOutput("t5_status_clr", bus.irq_status_o, 16'h0000);

      $display("[TB] release all inputs");
      applyStimulus(16'h0000);
      pushEvent(10, 16'h0000, 16'h000B, 16'h0000);
      waitCycles(12);
      checkOutput("fall_status", bus.irq_status_o, 16'h0001);
      checkOutput("fall_irq", {15'd0, bus.irq_o}, 16'h0001);

      $display("[TB] reset mid-count on ch2");
      applyStimulus(16'h0004);
      waitCycles(7);
      reset_n = 1'b0;
      waitCycles(1);
      checkOutput("t6_rst_db", bus.db_o, '0);
      checkOutput("t6_rst_rise", bus.rise_o, '0);
      checkOutput("t6_rst_fall", bus.fall_o, '0);
      checkOutput("t6_rst_status", bus.irq_status_o, '0);
      checkOutput("t6_rst_irq", {15'd0, bus.irq_o}, '0);
      reset_n = 1'b1;
      pushEvent(10, 16'h0004, 16'h0000, 16'h0004);
      waitCycles(9);
      checkOutput("t6_db_early", bus.db_o, 16'h0000);
      waitCycles(5);
      checkOutput("t6_db", bus.db_o, 16'h0004);
      checkOutput("t6_status", bus.irq_status_o, 16'h0000);
      waitCycles(2);

      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_drained: %0d events outstanding, expected 0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
